// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encodings and widths for the stopwatch controller
package stopwatch_pkg;

   localparam int STATE_W = 2;
   localparam int DIGITS  = 4;
   localparam int SEL_W   = $clog2(DIGITS);
   localparam int VAL_W   = 4;

   localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [STATE_W-1:0] ST_RUN    = 2'd1;
   localparam logic [STATE_W-1:0] ST_PAUSE  = 2'd2;
   localparam logic [STATE_W-1:0] ST_ADJUST = 2'd3;

endpackage

// File: rtl/pulse_div.sv
// rtl/pulse_div.sv - clock divider emitting a registered one-cycle pulse per wrap
module pulse_div #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic pulse
);

   localparam int W = $clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   // Count 0..DIV-1 while enabled and flag the wrap; clr restarts the period and drops any pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         pulse <= 1'b0;
      end else if (clr) begin
         cnt   <= '0;
         pulse <= 1'b0;
      end else if (en) begin
         if (cnt == LAST) begin
            cnt   <= '0;
            pulse <= 1'b1;
         end else begin
            cnt   <= cnt + W'(1);
            pulse <= 1'b0;
         end
      end else begin
         pulse <= 1'b0;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/adjust sequencer driving the stopwatch counter datapath
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DIV_TICK  = 100_000_000,
   parameter int DIV_BLINK = 25_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn_reset,
   input  logic               btn_pause,
   input  logic               adj,
   input  logic [SEL_W-1:0]   sel,
   input  logic [VAL_W-1:0]   num,
   output logic               cnt_en,
   output logic               cnt_clr,
   output logic               adj_wr,
   output logic [SEL_W-1:0]   adj_sel,
   output logic [VAL_W-1:0]   adj_val,
   output logic               blink,
   output logic [STATE_W-1:0] state
);

   logic                btn_reset_q;
   logic                btn_pause_q;
   logic                rise_reset;
   logic                rise_pause;
   logic [STATE_W-1:0]  state_nxt;
   logic                wr_fire;
   logic                tick_en;
   logic                tick_clr;
   logic                blink_pulse;

   assign rise_reset = btn_reset & ~btn_reset_q;
   assign rise_pause = btn_pause & ~btn_pause_q;

   // A held adj switch outranks the pause button, so a write only happens while adj stays high
   assign wr_fire  = (state == ST_ADJUST) & adj & rise_pause & ~rise_reset;
   assign tick_en  = (state == ST_RUN);
   assign tick_clr = rise_reset | ((state == ST_IDLE) & ~adj & rise_pause);

   pulse_div #(.DIV(DIV_TICK)) u_tick_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (tick_en),
      .clr   (tick_clr),
      .pulse (cnt_en)
   );

   pulse_div #(.DIV(DIV_BLINK)) u_blink_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .clr   (1'b0),
      .pulse (blink_pulse)
   );

   // Next-state selection: reset button first, then the adj level, then the pause edge
   always_comb begin
      state_nxt = state;
      if (rise_reset) begin
         state_nxt = adj ? ST_ADJUST : ST_IDLE;
      end else if (adj) begin
         state_nxt = ST_ADJUST;
      end else begin
         case (state)
            ST_IDLE:   if (rise_pause) state_nxt = ST_RUN;
            ST_RUN:    if (rise_pause) state_nxt = ST_PAUSE;
            ST_PAUSE:  if (rise_pause) state_nxt = ST_RUN;
            default:   state_nxt = ST_PAUSE;
         endcase
      end
   end

   // Button history, FSM state, clear and write strobes, and the adjust-digit capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_reset_q <= 1'b0;
         btn_pause_q <= 1'b0;
         state       <= ST_IDLE;
         cnt_clr     <= 1'b0;
         adj_wr      <= 1'b0;
         adj_sel     <= '0;
         adj_val     <= '0;
      end else begin
         btn_reset_q <= btn_reset;
         btn_pause_q <= btn_pause;
         state       <= state_nxt;
         cnt_clr     <= rise_reset;
         adj_wr      <= wr_fire;
         if (wr_fire) begin
            adj_sel <= sel;
            adj_val <= num;
         end
      end
   end

   // Blink toggles on each blink-divider wrap inside ADJUST and is parked low everywhere else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink <= 1'b0;
      end else if (state_nxt != ST_ADJUST) begin
         blink <= 1'b0;
      end else if (blink_pulse) begin
         blink <= ~blink;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for the stopwatch mode sequencer
module tb_stopwatch_ctrl;

   localparam int K_TICK = 0;
   localparam int K_CLR  = 1;
   localparam int K_WR   = 2;

   typedef struct {
      int         kind;
      int         cyc;
      logic [1:0] sel;
      logic [3:0] val;
   } ev_t;

   logic       clk;
   logic       rst_n;
   logic       btn_reset;
   logic       btn_pause;
   logic       adj;
   logic [1:0] sel;
   logic [3:0] num;
   logic       cnt_en;
   logic       cnt_clr;
   logic       adj_wr;
   logic [1:0] adj_sel;
   logic [3:0] adj_val;
   logic       blink;
   logic [1:0] state;

   int  cyc = 0;
   int  n_checks = 0;
   int  n_pass = 0;
   ev_t exp_q[$];

   stopwatch_ctrl #(.DIV_TICK(10), .DIV_BLINK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_reset (btn_reset),
      .btn_pause (btn_pause),
      .adj       (adj),
      .sel       (sel),
      .num       (num),
      .cnt_en    (cnt_en),
      .cnt_clr   (cnt_clr),
      .adj_wr    (adj_wr),
      .adj_sel   (adj_sel),
      .adj_val   (adj_val),
      .blink     (blink),
      .state     (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic expect_ev(input int kind, input int c, input logic [1:0] s, input logic [3:0] v);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.sel  = s;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Monitor: every strobe the DUT raises is matched against the next expected event
   always @(negedge clk) begin
      if (cnt_en || cnt_clr || adj_wr) begin
         int  kind;
         ev_t e;
         kind = cnt_en ? K_TICK : (cnt_clr ? K_CLR : K_WR);
         check("en_clr_exclusive", int'(cnt_en & cnt_clr), 0);
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
         end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            if (e.kind == K_WR) begin
               check("wr_sel", int'(adj_sel), int'(e.sel));
               check("wr_val", int'(adj_val), int'(e.val));
            end
         end
      end
   end

   initial begin
      int b;
      int prev_blink;
      int last_tog;
      int toggles;
      rst_n     = 1'b0;
      btn_reset = 1'b0;
      btn_pause = 1'b0;
      adj       = 1'b0;
      sel       = 2'd0;
      num       = 4'd0;
      repeat (3) @(negedge clk);
      check("reset_state", int'(state), 0);
      check("reset_outputs", int'({cnt_en, cnt_clr, adj_wr, blink, adj_sel, adj_val}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset", int'(state), 0);

      // 1: press and hold pause 35 cycles; ticks every 10 cycles from entry
      b = cyc;
      btn_pause = 1'b1;
      expect_ev(K_TICK, b + 11, 2'd0, 4'd0);
      expect_ev(K_TICK, b + 21, 2'd0, 4'd0);
      expect_ev(K_TICK, b + 31, 2'd0, 4'd0);
      expect_ev(K_TICK, b + 41, 2'd0, 4'd0);
      wait_until(b + 1);
      check("enter_run", int'(state), 1);
      wait_until(b + 35);
      check("run_held", int'(state), 1);
      check("blink_off_run", int'(blink), 0);
      btn_pause = 1'b0;

      // 2: pause with divider at 4, sit 20 cycles, resume; next tick 6 cycles later
      wait_until(b + 44);
      btn_pause = 1'b1;
      wait_until(b + 45);
      check("enter_pause", int'(state), 2);
      btn_pause = 1'b0;
      wait_until(b + 65);
      btn_pause = 1'b1;
      expect_ev(K_TICK, b + 72, 2'd0, 4'd0);
      wait_until(b + 66);
      check("resume_run", int'(state), 1);
      btn_pause = 1'b0;

      // 3: adjust mode, one digit write, blink cadence, exit to PAUSE
      wait_until(b + 73);
      adj = 1'b1;
      sel = 2'd2;
      num = 4'd7;
      wait_until(b + 74);
      check("enter_adjust", int'(state), 3);
      wait_until(b + 75);
      btn_pause = 1'b1;
      expect_ev(K_WR, b + 76, 2'd2, 4'd7);
      wait_until(b + 76);
      btn_pause = 1'b0;
      wait_until(b + 78);
      sel = 2'd1;
      num = 4'd3;
      wait_until(b + 80);
      prev_blink = int'(blink);
      last_tog = -1;
      toggles = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (int'(blink) != prev_blink) begin
            if (last_tog >= 0) check("blink_period", cyc - last_tog, 4);
            last_tog = cyc;
            toggles++;
            prev_blink = int'(blink);
         end
      end
      check("blink_toggles", toggles, 4);
      wait_until(b + 100);
      adj = 1'b0;
      wait_until(b + 101);
      check("adjust_to_pause", int'(state), 2);
      check("blink_off_pause", int'(blink), 0);
      check("adj_sel_held", int'(adj_sel), 2);
      check("adj_val_held", int'(adj_val), 7);

      // 4: reset and pause rising together in RUN, then a long pause hold
      wait_until(b + 102);
      btn_pause = 1'b1;
      wait_until(b + 103);
      check("pause_to_run", int'(state), 1);
      btn_pause = 1'b0;
      wait_until(b + 105);
      btn_reset = 1'b1;
      btn_pause = 1'b1;
      expect_ev(K_CLR, b + 106, 2'd0, 4'd0);
      wait_until(b + 106);
      check("reset_wins", int'(state), 0);
      btn_reset = 1'b0;
      wait_until(b + 156);
      check("held_pause_no_action", int'(state), 0);
      btn_pause = 1'b0;

      // 4b: reset press lands exactly on the tick wrap; clear only
      wait_until(b + 157);
      btn_pause = 1'b1;
      wait_until(b + 158);
      check("idle_to_run", int'(state), 1);
      btn_pause = 1'b0;
      wait_until(b + 167);
      btn_reset = 1'b1;
      expect_ev(K_CLR, b + 168, 2'd0, 4'd0);
      wait_until(b + 168);
      check("wrap_reset_idle", int'(state), 0);
      btn_reset = 1'b0;

      // 5: reset press while adjusting keeps ADJUST
      wait_until(b + 170);
      adj = 1'b1;
      wait_until(b + 171);
      check("idle_to_adjust", int'(state), 3);
      wait_until(b + 172);
      btn_reset = 1'b1;
      expect_ev(K_CLR, b + 173, 2'd0, 4'd0);
      wait_until(b + 173);
      check("reset_in_adjust", int'(state), 3);
      btn_reset = 1'b0;
      wait_until(b + 174);
      adj = 1'b0;
      wait_until(b + 175);
      check("adjust_exit_pause", int'(state), 2);

      // 6: async rst_n with the tick divider at 7, then a full period after restart
      wait_until(b + 176);
      btn_pause = 1'b1;
      wait_until(b + 177);
      btn_pause = 1'b0;
      wait_until(b + 184);
      check("run_before_rst", int'(state), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_state", int'(state), 0);
      check("async_outputs", int'({cnt_en, cnt_clr, adj_wr, blink, adj_sel, adj_val}), 0);
      wait_until(b + 186);
      rst_n = 1'b1;
      wait_until(b + 188);
      btn_pause = 1'b1;
      expect_ev(K_TICK, b + 199, 2'd0, 4'd0);
      wait_until(b + 189);
      check("restart_run", int'(state), 1);
      btn_pause = 1'b0;
      wait_until(b + 205);
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
